// File: rtl/alu_arbiter_8bit.sv
// Two-requester round-robin arbiter in front of a shared 8-bit ALU.
// Latency: grant at edge k, result in Y and ack pulse at edge k+1, back to IDLE at edge k+2.
// Backpressure: requesters hold req until ack; requests seen during EXEC/DONE wait for IDLE.
//
// Ports: clk, rst_n (sync, active-low); req0/op0/a0/b0 and req1/op1/a1/b1 request inputs;
//        ack0/ack1 one-cycle completion pulses; Y registered result; busy high in EXEC/DONE.
// Optional: define ALU_ARB_FLAGS_EN to add registered zf/cf/vf flag outputs.
module alu_arbiter_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] Y,
  output logic             busy
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic             zf,
  output logic             cf,
  output logic             vf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic             owner;      // requester whose operands are latched
  logic             prio;       // requester preferred when both ask
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             grant_vld;
  logic             grant_sel;
  logic [WIDTH-1:0] res;

  // Lone request wins outright; a tie goes to whoever was not granted last.
  always_comb begin
    grant_vld = req0 | req1;
    grant_sel = (req0 && req1) ? prio : req1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res = '0;
    case (op_q)
      3'b000: res = a_q & b_q;
      3'b001: res = a_q | b_q;
      3'b010: res = a_q ^ b_q;
      3'b011: res = a_q + b_q;
      3'b100: res = a_q - b_q;
      3'b101: res = ~a_q;
      3'b110: res = {a_q[WIDTH-2:0], 1'b0};
      3'b111: res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: res = '0;
    endcase
  end

`ifdef ALU_ARB_FLAGS_EN
  logic zf_nxt, cf_nxt, vf_nxt;

  // Carry of an unsigned add shows up as the wrapped sum being below an operand;
  // borrow of a subtract is simply a < b unsigned.
  always_comb begin
    zf_nxt = (res == '0);
    cf_nxt = 1'b0;
    vf_nxt = 1'b0;
    if (op_q == 3'b011) begin
      cf_nxt = (res < a_q);
      vf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
    end else if (op_q == 3'b100) begin
      cf_nxt = (a_q < b_q);
      vf_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      Y     <= '0;
`ifdef ALU_ARB_FLAGS_EN
      zf    <= 1'b0;
      cf    <= 1'b0;
      vf    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner <= grant_sel;
            prio  <= ~grant_sel;
            op_q  <= grant_sel ? op1 : op0;
            a_q   <= grant_sel ? a1  : a0;
            b_q   <= grant_sel ? b1  : b0;
          end
        end
        EXEC: begin
          Y    <= res;
          ack0 <= ~owner;
          ack1 <= owner;
`ifdef ALU_ARB_FLAGS_EN
          zf   <= zf_nxt;
          cf   <= cf_nxt;
          vf   <= vf_nxt;
`endif
        end
        default: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter_8bit.sv
module tb_alu_arbiter_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       ack0, ack1, busy;
  logic [7:0] Y;
`ifdef ALU_ARB_FLAGS_EN
  logic       zf, cf, vf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .Y(Y), .busy(busy)
`ifdef ALU_ARB_FLAGS_EN
    , .zf(zf), .cf(cf), .vf(vf)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 1'b0; op0 = 3'b000; a0 = 8'h00; b0 = 8'h00;
    req1 = 1'b0; op1 = 3'b000; a1 = 8'h00; b1 = 8'h00;
    tick; tick;
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack0 got=%b want=0", ack0); end
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL reset_ack1 got=%b want=0", ack1); end
    total++; if (Y !== 8'h00)   begin bad++; $display("FAIL reset_y got=%h want=00", Y); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef ALU_ARB_FLAGS_EN
    total++; if ({zf, cf, vf} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {zf, cf, vf}); end
`endif
    rst_n = 1'b1;
  endtask

  // 0x7F + 0x01 = 0x80: signed overflow, no carry.
  task automatic test_add_overflow;
    req0 = 1'b1; op0 = 3'b011; a0 = 8'h7F; b0 = 8'h01;
    tick;  // grant
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL addov_busy_exec got=%b want=1", busy); end
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL addov_ack0_early got=%b want=0", ack0); end
    tick;  // result
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL addov_ack0 got=%b want=1", ack0); end
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL addov_ack1 got=%b want=0", ack1); end
    total++; if (Y !== 8'h80)   begin bad++; $display("FAIL addov_y got=%h want=80", Y); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL addov_busy_done got=%b want=1", busy); end
`ifdef ALU_ARB_FLAGS_EN
    total++; if ({zf, cf, vf} !== 3'b001) begin bad++; $display("FAIL addov_flags got=%b want=001", {zf, cf, vf}); end
`endif
    req0 = 1'b0;
    tick;  // back to idle
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL addov_ack0_drop got=%b want=0", ack0); end
    total++; if (Y !== 8'h80)   begin bad++; $display("FAIL addov_y_hold got=%h want=80", Y); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL addov_busy_idle got=%b want=0", busy); end
  endtask

  // Both requesters pending straight out of reset: 0 first, then 1 three cycles later.
  task automatic test_both_from_reset;
    rst_n = 1'b0;
    req0 = 1'b1; op0 = 3'b000; a0 = 8'hF0; b0 = 8'h3C;
    req1 = 1'b1; op1 = 3'b100; a1 = 8'h05; b1 = 8'h07;
    tick; tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL both_busy_in_reset got=%b want=0", busy); end
    rst_n = 1'b1;
    tick;  // grant 0
    tick;
    total++; if ({ack0, ack1} !== 2'b10) begin bad++; $display("FAIL both_first_ack got=%b want=10", {ack0, ack1}); end
    total++; if (Y !== 8'h30) begin bad++; $display("FAIL both_first_y got=%h want=30", Y); end
    req0 = 1'b0;
    tick;
    total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL both_gap_ack got=%b want=00", {ack0, ack1}); end
    tick;  // grant 1
    total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL both_gap2_ack got=%b want=00", {ack0, ack1}); end
    tick;
    total++; if ({ack0, ack1} !== 2'b01) begin bad++; $display("FAIL both_second_ack got=%b want=01", {ack0, ack1}); end
    total++; if (Y !== 8'hFE) begin bad++; $display("FAIL both_second_y got=%h want=fe", Y); end
`ifdef ALU_ARB_FLAGS_EN
    total++; if ({zf, cf, vf} !== 3'b010) begin bad++; $display("FAIL both_second_flags got=%b want=010", {zf, cf, vf}); end
`endif
    req1 = 1'b0;
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL both_end_busy got=%b want=0", busy); end
  endtask

  // req1 held the whole time, req0 re-raised after each of its acks: grants alternate.
  task automatic test_round_robin;
    logic [3:0] who;
    who = 4'b1010;  // bit i = expected owner of grant i
    req1 = 1'b1; op1 = 3'b010; a1 = 8'hFF; b1 = 8'h0F;
    req0 = 1'b1; op0 = 3'b001; a0 = 8'h0F; b0 = 8'h30;
    for (int i = 0; i < 4; i++) begin
      tick;  // grant
      total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL rr_exec_ack[%0d] got=%b want=00", i, {ack0, ack1}); end
      tick;
      total++;
      if ({ack0, ack1} !== (who[i] ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", i, {ack0, ack1}, who[i] ? 2'b01 : 2'b10);
      end
      total++;
      if (Y !== (who[i] ? 8'hF0 : 8'h3F)) begin
        bad++; $display("FAIL rr_y[%0d] got=%h want=%h", i, Y, who[i] ? 8'hF0 : 8'h3F);
      end
      if (!who[i]) req0 = 1'b0;
      tick;
      if (i < 3) req0 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;
  endtask

  // Operands and req change right after grant; the latched 0x81 >>> 1 must win.
  task automatic test_latch;
    req0 = 1'b1; op0 = 3'b111; a0 = 8'h81; b0 = 8'h00;
    tick;  // grant
    a0 = 8'h00; op0 = 3'b001; req0 = 1'b0;
    tick;
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL latch_ack0 got=%b want=1", ack0); end
    total++; if (Y !== 8'hC0)   begin bad++; $display("FAIL latch_y got=%h want=c0", Y); end
    tick;
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL latch_no_regrant got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_op;
    req0 = 1'b1; op0 = 3'b011; a0 = 8'h01; b0 = 8'h02;
    tick;  // grant, now EXEC
    rst_n = 1'b0; req0 = 1'b0;
    tick;
    total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL rstmid_ack got=%b want=00", {ack0, ack1}); end
    total++; if (Y !== 8'h00)   begin bad++; $display("FAIL rstmid_y got=%h want=00", Y); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    tick;
    total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL rstmid_late_ack got=%b want=00", {ack0, ack1}); end
    req0 = 1'b1; op0 = 3'b100; a0 = 8'h10; b0 = 8'h01;
    tick; tick;
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL rstmid_after_ack0 got=%b want=1", ack0); end
    total++; if (Y !== 8'h0F)   begin bad++; $display("FAIL rstmid_after_y got=%h want=0f", Y); end
    req0 = 1'b0;
    tick;
  endtask

  // 0xFF + 0x01 wraps to zero with carry out.
  task automatic test_add_wrap;
    req1 = 1'b1; op1 = 3'b011; a1 = 8'hFF; b1 = 8'h01;
    tick; tick;
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL wrap_ack1 got=%b want=1", ack1); end
    total++; if (Y !== 8'h00)   begin bad++; $display("FAIL wrap_y got=%h want=00", Y); end
`ifdef ALU_ARB_FLAGS_EN
    total++; if ({zf, cf, vf} !== 3'b110) begin bad++; $display("FAIL wrap_flags got=%b want=110", {zf, cf, vf}); end
`endif
    req1 = 1'b0;
    tick;
  endtask

  // Remaining opcodes, alternating the requester used.
  task automatic test_opcodes;
    logic [2:0] t_op [6];
    logic [7:0] t_a  [6];
    logic [7:0] t_b  [6];
    logic [7:0] t_y  [6];
    logic [2:0] t_f  [6];  // {zf, cf, vf}
    t_op[0] = 3'b101; t_a[0] = 8'h5A; t_b[0] = 8'h00; t_y[0] = 8'hA5; t_f[0] = 3'b000;
    t_op[1] = 3'b110; t_a[1] = 8'hC3; t_b[1] = 8'h00; t_y[1] = 8'h86; t_f[1] = 3'b000;
    t_op[2] = 3'b100; t_a[2] = 8'h80; t_b[2] = 8'h01; t_y[2] = 8'h7F; t_f[2] = 3'b001;
    t_op[3] = 3'b111; t_a[3] = 8'h7E; t_b[3] = 8'h00; t_y[3] = 8'h3F; t_f[3] = 3'b000;
    t_op[4] = 3'b010; t_a[4] = 8'hAA; t_b[4] = 8'hAA; t_y[4] = 8'h00; t_f[4] = 3'b100;
    t_op[5] = 3'b001; t_a[5] = 8'h12; t_b[5] = 8'h21; t_y[5] = 8'h33; t_f[5] = 3'b000;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        req0 = 1'b1; op0 = t_op[i]; a0 = t_a[i]; b0 = t_b[i];
      end else begin
        req1 = 1'b1; op1 = t_op[i]; a1 = t_a[i]; b1 = t_b[i];
      end
      tick; tick;
      total++;
      if ({ack0, ack1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL op_ack[%0d] got=%b want=%b", i, {ack0, ack1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      total++; if (Y !== t_y[i]) begin bad++; $display("FAIL op_y[%0d] got=%h want=%h", i, Y, t_y[i]); end
`ifdef ALU_ARB_FLAGS_EN
      total++; if ({zf, cf, vf} !== t_f[i]) begin bad++; $display("FAIL op_flags[%0d] got=%b want=%b", i, {zf, cf, vf}, t_f[i]); end
`endif
      req0 = 1'b0; req1 = 1'b0;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_both_from_reset;
    test_round_robin;
    test_latch;
    test_reset_mid_op;
    test_add_wrap;
    test_opcodes;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // The two acks must never be high together.
  always @(negedge clk) begin
    if (ack0 && ack1) begin
      total++;
      bad++;
      $display("FAIL ack_overlap got=11 want=not_both");
    end
  end

endmodule

// File: doc/alu_arbiter_8bit.md
ALU_ARBITER_8BIT -- requirements
Module: alu_arbiter_8bit

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width; only value 8 supported.
REQ-002 Port: clk  in  1  sole clock, rising-edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Port: req0  in  1  requester 0 request, held high until ack0.
REQ-005 Port: op0  in  3  requester 0 opcode.
REQ-006 Port: a0  in  8  requester 0 operand A, signed.
REQ-007 Port: b0  in  8  requester 0 operand B, signed.
REQ-008 Port: req1, op1, a1, b1  in  1/3/8/8  requester 1, same meaning as requester 0.
REQ-009 Port: ack0  out  1  one-cycle pulse; Y valid for requester 0.
REQ-010 Port: ack1  out  1  one-cycle pulse; Y valid for requester 1.
REQ-011 Port: Y  out  8  registered signed result, held until next completion.
REQ-012 Port: busy  out  1  high in states EXEC and DONE.

Function
REQ-013 Opcodes SHALL be: 000 A&B, 001 A|B, 010 A^B, 011 A+B, 100 A-B, 101 ~A, 110 A<<1, 111 A>>>1 (arithmetic).
REQ-014 Add/sub SHALL wrap modulo 256; shifts SHALL be 1 bit; no saturation.
REQ-015 FSM SHALL have states IDLE, EXEC, DONE; encoding is implementation choice.
REQ-016 IDLE: at edge k with any req high, SHALL select a requester, latch its op/a/b, record it as owner, go to EXEC.
REQ-017 Exactly one req high in IDLE: that requester SHALL be selected.
REQ-018 Both req high in IDLE: SHALL select the requester not granted most recently (round-robin); after reset requester 0 has priority.
REQ-019 EXEC: at edge k+1 SHALL register result into Y, assert owner's ack, go to DONE.
REQ-020 DONE: at edge k+2 SHALL deassert ack, go to IDLE; fixed latency, ack high exactly during cycle after edge k+1.
REQ-021 Operands SHALL come only from the latch; changes to op/a/b or req drop after edge k SHALL NOT affect result or ack.
REQ-022 Requester SHALL drop req in its ack cycle; req still high in IDLE SHALL be treated as a new request (subject to round-robin).
REQ-023 req arriving during EXEC/DONE SHALL wait; no request SHALL be lost while held high.
REQ-024 ack0 and ack1 SHALL never be high together; Y SHALL change only at EXEC->DONE edge.
REQ-025 Peak throughput SHALL be one operation per 3 cycles.

Reset
REQ-026 rst_n low at a rising edge SHALL force state IDLE, ack0=ack1=0, Y=0, busy=0, priority to requester 0, flags 0.
REQ-027 Reset mid-operation SHALL abort it; no ack SHALL be issued for the aborted operation.
REQ-028 Reset SHALL be sampled only on clk rising edges.

Configuration
REQ-029 Macro ALU_ARB_FLAGS_EN SHALL, when defined, add outputs zf (Y==0), cf (carry/borrow out of add/sub, 0 otherwise), vf (signed overflow of add/sub, 0 otherwise), each 1 bit, registered with Y.
REQ-030 Without ALU_ARB_FLAGS_EN, ports zf/cf/vf SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset then req0=1, op0=011, a0=0x7F, b0=0x01 -> ack0 high 2 edges later, Y=0x80 (flags: zf=0, cf=0, vf=1).
REQ-032 req0 and req1 both high from reset, op0=000 a0=0xF0 b0=0x3C, op1=100 a1=0x05 b1=0x07 -> ack0 first Y=0x30, then ack1 Y=0xFE (cf=1), three cycles apart.
REQ-033 req1 held continuously, req0 re-raised after each ack0 -> grants alternate 0,1,0,1; no ack overlap.
REQ-034 req0 op0=111 a0=0x81, change a0 to 0x00 one cycle after grant -> Y=0xC0.
REQ-035 Assert rst_n=0 during EXEC -> no ack, Y=0, busy=0 next cycle; subsequent request completes normally.
REQ-036 op0=011 a0=0xFF b0=0x01 -> Y=0x00, zf=1, cf=1, vf=0.
